// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the cache/memory line-burst arbiter.
// Grant encoding doubles as the index into the arbiter request vector.
package cache_mem_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_WDATA = 3'd2,
      ST_RDATA = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic GRANT_IC = 1'b0;
   localparam logic GRANT_DC = 1'b1;

endpackage

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: req[0]=icache, req[1]=dcache.
// On contention the side that did not win last time is granted.
module cache_mem_arbiter_rr_arb2
   import cache_mem_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic last_grant_r;

   // Remember who won the most recent grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_r <= GRANT_IC;
      end else if (advance && (req != 2'b00)) begin
         last_grant_r <= gnt[1];
      end else begin
         last_grant_r <= last_grant_r;
      end
   end

   // Grant decode from the current requests and the last winner
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_grant_r == GRANT_IC) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one line-burst memory port between icache refills and dcache refills/write-backs.
// One transaction in flight; beats pass straight through without buffering.
module cache_mem_arbiter
   import cache_mem_arbiter_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int LINE_BEATS = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ic_req_valid,
   output logic          ic_req_ready,
   input  logic [AW-1:0] ic_req_addr,
   output logic [DW-1:0] ic_rdata,
   output logic          ic_rvalid,
   output logic          ic_done,
   input  logic          dc_req_valid,
   output logic          dc_req_ready,
   input  logic [AW-1:0] dc_req_addr,
   input  logic          dc_req_we,
   input  logic [DW-1:0] dc_wdata,
   output logic          dc_wdata_ready,
   output logic [DW-1:0] dc_rdata,
   output logic          dc_rvalid,
   output logic          dc_done,
   output logic          mem_cmd_valid,
   input  logic          mem_cmd_ready,
   output logic [AW-1:0] mem_cmd_addr,
   output logic          mem_cmd_rnw,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_wdata_valid,
   input  logic          mem_wdata_ready,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_rdata_valid,
   output logic          proto_err
);

   localparam int            CW        = $clog2(LINE_BEATS);
   localparam logic [AW-1:0] LINE_MASK = AW'(LINE_BEATS * DW / 8 - 1);

   state_t          state_r, state_s;
   logic            grant_r;
   logic            rnw_r;
   logic [AW-1:0]   addr_r;
   logic [CW-1:0]   cnt_r;
   logic            proto_err_r;
   logic [1:0]      gnt_s;
   logic            accept_s;
   logic            cnt_last_s;
   logic [AW-1:0]   sel_addr_s;

   assign accept_s   = (state_r == ST_IDLE) && (ic_req_valid || dc_req_valid);
   assign cnt_last_s = (cnt_r == CW'(LINE_BEATS - 1));
   assign sel_addr_s = gnt_s[1] ? dc_req_addr : ic_req_addr;
   assign proto_err  = proto_err_r;

   cache_mem_arbiter_rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     ({dc_req_valid, ic_req_valid}),
      .advance (accept_s),
      .gnt     (gnt_s)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE:  state_s = accept_s ? ST_CMD : ST_IDLE;
         ST_CMD: begin
            if (mem_cmd_ready) begin
               state_s = rnw_r ? ST_RDATA : ST_WDATA;
            end else begin
               state_s = ST_CMD;
            end
         end
         ST_WDATA: state_s = (mem_wdata_ready && cnt_last_s) ? ST_DONE : ST_WDATA;
         ST_RDATA: state_s = (mem_rdata_valid && cnt_last_s) ? ST_DONE : ST_RDATA;
         ST_DONE:  state_s = ST_IDLE;
         default:  state_s = ST_IDLE;
      endcase
   end

   // Latched command, beat counter and sticky protocol error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_r      <= {AW{1'b0}};
         rnw_r       <= 1'b0;
         grant_r     <= GRANT_IC;
         cnt_r       <= {CW{1'b0}};
         proto_err_r <= 1'b0;
      end else begin
         if (accept_s) begin
            addr_r  <= sel_addr_s & ~LINE_MASK;
            rnw_r   <= gnt_s[1] ? ~dc_req_we : 1'b1;
            grant_r <= gnt_s[1];
         end
         // Counter wraps to zero on the final beat because LINE_BEATS is a power of two
         if ((state_r == ST_WDATA && mem_wdata_ready) ||
             (state_r == ST_RDATA && mem_rdata_valid)) begin
            cnt_r <= cnt_r + CW'(1);
         end else if (state_r == ST_DONE) begin
            cnt_r <= {CW{1'b0}};
         end
         if (mem_rdata_valid && (state_r != ST_RDATA)) begin
            proto_err_r <= 1'b1;
         end
      end
   end

   // FSM outputs and data steering
   always_comb begin
      ic_req_ready    = 1'b0;
      dc_req_ready    = 1'b0;
      ic_rdata        = {DW{1'b0}};
      dc_rdata        = {DW{1'b0}};
      ic_rvalid       = 1'b0;
      dc_rvalid       = 1'b0;
      ic_done         = 1'b0;
      dc_done         = 1'b0;
      dc_wdata_ready  = 1'b0;
      mem_cmd_valid   = 1'b0;
      mem_cmd_addr    = {AW{1'b0}};
      mem_cmd_rnw     = 1'b0;
      mem_wdata       = {DW{1'b0}};
      mem_wdata_valid = 1'b0;
      case (state_r)
         ST_IDLE: begin
            ic_req_ready = rst_n & gnt_s[0];
            dc_req_ready = rst_n & gnt_s[1];
         end
         ST_CMD: begin
            mem_cmd_valid = 1'b1;
            mem_cmd_addr  = addr_r;
            mem_cmd_rnw   = rnw_r;
         end
         ST_WDATA: begin
            mem_wdata       = dc_wdata;
            mem_wdata_valid = 1'b1;
            dc_wdata_ready  = mem_wdata_ready;
         end
         ST_RDATA: begin
            ic_rdata  = mem_rdata;
            dc_rdata  = mem_rdata;
            ic_rvalid = mem_rdata_valid & (grant_r == GRANT_IC);
            dc_rvalid = mem_rdata_valid & (grant_r == GRANT_DC);
         end
         ST_DONE: begin
            ic_done = (grant_r == GRANT_IC);
            dc_done = (grant_r == GRANT_DC);
         end
         default: begin
            ic_req_ready = 1'b0;
         end
      endcase
   end

endmodule
